// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard / stall / flush controller for a 5-stage in-order pipeline.
//   A small three-state machine (RUN, MEMWAIT, HALT) is held in a register.
//   All control outputs are decoded combinationally from that state and the
//   current-cycle inputs.
//
//   Priority in RUN (and in MEMWAIT once mem_busy drops):
//     mem_busy > ex_branch_taken > load-use > halt_req
//
//   Optional feature:
//     PIPE_HAZARD_STALL_CNT_EN : when defined, stall_cnt counts the cycles in
//                                which pc_pause is high, saturating at all-ones.
//                                When undefined, stall_cnt is tied to zero and
//                                no counter register exists.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   id_rs, id_rt      : source register fields of the ID instruction
//   id_use_rs/_rt     : ID instruction actually reads rs / rt
//   ex_memread, ex_rd : EX instruction is a load, and its destination
//   ex_branch_taken   : taken branch/jump resolved in EX
//   mem_busy          : data memory wait request
//   halt_req, go      : ID instruction is a halt / resume while halted
//   *_pause           : hold PC or the named pipeline register
//   ifid/idex_flush   : load a bubble into IF/ID or ID/EX
//   halted            : high while in HALT
//   stall_cnt         : stall-cycle counter (see above)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    input  logic        halt_req,
    input  logic        go,
    output logic        pc_pause,
    output logic        ifid_pause,
    output logic        idex_pause,
    output logic        exmem_pause,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   load_use;

    // Register 0 is hard-wired to zero, so a load targeting it never
    // creates a dependency.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) ||
                       (id_use_rt && (id_rt == ex_rd)));

    always_comb begin
        state_d     = state_q;
        pc_pause    = 1'b0;
        ifid_pause  = 1'b0;
        idex_pause  = 1'b0;
        exmem_pause = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        halted      = 1'b0;

        if (rst) begin
            state_d = RUN;
        end else if (state_q == HALT) begin
            // HALT ignores memory, branch and further halt requests; the
            // go cycle itself still shows HALT outputs.
            pc_pause   = 1'b1;
            ifid_pause = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b1;
            if (go) state_d = RUN;
        end else begin
            // RUN and MEMWAIT share one decode: MEMWAIT only differs in that
            // it was entered by mem_busy, which is re-evaluated every cycle.
            if (mem_busy) begin
                pc_pause    = 1'b1;
                ifid_pause  = 1'b1;
                idex_pause  = 1'b1;
                exmem_pause = 1'b1;
                state_d     = MEMWAIT;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = RUN;
            end else if (load_use) begin
                pc_pause   = 1'b1;
                ifid_pause = 1'b1;
                idex_flush = 1'b1;
                state_d    = RUN;
            end else if (halt_req) begin
                pc_pause   = 1'b1;
                ifid_pause = 1'b1;
                state_d    = HALT;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // pc_pause is already forced low during reset, so no extra rst gating
    // is needed on the increment.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= 32'h0;
        else if (pc_pause && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_use_rs, id_use_rt, ex_memread, ex_branch_taken;
    logic        mem_busy, halt_req, go;
    logic        pc_pause, ifid_pause, idex_pause, exmem_pause;
    logic        ifid_flush, idex_flush, halted;
    logic [31:0] stall_cnt;

    int nchk = 0;
    int nerr = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .halt_req(halt_req), .go(go),
        .pc_pause(pc_pause), .ifid_pause(ifid_pause),
        .idex_pause(idex_pause), .exmem_pause(exmem_pause),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The only architectural memory that affects outputs is "are we halted";
    // a memory wait decodes exactly like RUN on every cycle.
    bit          m_halted = 1'b0;
    logic [31:0] m_cnt    = 32'h0;

    function automatic bit dep(input logic [4:0] src, input logic use_it);
        return use_it && ex_memread && ex_rd != 0 && src == ex_rd;
    endfunction

    // {pc, ifid, idex, exmem, ifid_flush, idex_flush, halted}
    function automatic logic [6:0] m_out();
        if (rst)                                   return 7'b0000000;
        if (m_halted)                              return 7'b1100011;
        if (mem_busy)                              return 7'b1111000;
        if (ex_branch_taken)                       return 7'b0000110;
        if (dep(id_rs, id_use_rs) || dep(id_rt, id_use_rt)) return 7'b1100010;
        if (halt_req)                              return 7'b1100000;
        return 7'b0000000;
    endfunction

    always @(posedge clk) begin
        logic [6:0] e;
        e = m_out();
        if (rst) begin
            m_halted = 1'b0;
            m_cnt    = 32'h0;
        end else begin
`ifdef PIPE_HAZARD_STALL_CNT_EN
            if (e[6] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
            if (m_halted) m_halted = !go;
            else if (e == 7'b1100000) m_halted = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [6:0] a, e;
        a = {pc_pause, ifid_pause, idex_pause, exmem_pause, ifid_flush, idex_flush, halted};
        e = m_out();
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL model_outs t=%0t got %b expected %b", $time, a, e);
        end
        nchk++;
        if (stall_cnt !== m_cnt) begin
            nerr++;
            $display("FAIL model_cnt t=%0t got %0d expected %0d", $time, stall_cnt, m_cnt);
        end
    end

    // ---------------- directed stimulus + literal checks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_memread = 0; ex_rd = 0; ex_branch_taken = 0;
        mem_busy = 0; halt_req = 0; go = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    function automatic logic [6:0] outs();
        return {pc_pause, ifid_pause, idex_pause, exmem_pause, ifid_flush, idex_flush, halted};
    endfunction

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
        ex_memread = 1; ex_rd = rd; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    endtask

    initial begin
        clr();
        rst = 1; mem_busy = 1; go = 1; halt_req = 1;
        settle();
        chk("reset_outs_zero", {25'b0, outs()}, 32'h0);
        tick(); tick();
        rst = 0; clr();
        settle();
        chk("post_reset_outs", {25'b0, outs()}, 32'h0);
        chk("post_reset_cnt", stall_cnt, 32'h0);

        // four load-use stalls, each for exactly one cycle
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_lu(5'd5,  5'd5,  1, 5'd0,  0);
                1: set_lu(5'd9,  5'd1,  1, 5'd9,  1);
                2: set_lu(5'd31, 5'd31, 1, 5'd31, 1);
                default: set_lu(5'd12, 5'd12, 1, 5'd3, 0);
            endcase
            settle();
            chk("lu_stall", {25'b0, outs()}, 32'h62);
            tick(); clr();
            settle();
            chk("lu_released", {25'b0, outs()}, 32'h0);
            tick();
        end

        // mem_busy 3 cycles with branch pending, then branch flush
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1; ex_branch_taken = 1;
            settle();
            chk("busy_pauses", {25'b0, outs()}, 32'h78);
            tick();
        end
        mem_busy = 0;
        settle();
        chk("busy_then_branch", {25'b0, outs()}, 32'h06);
        tick(); clr();
        settle();
`ifdef PIPE_HAZARD_STALL_CNT_EN
        chk("stall_cnt_7", stall_cnt, 32'd7);
`else
        chk("stall_cnt_0", stall_cnt, 32'd0);
`endif

        // non-hazards: r0 destination, unused operand, not a load
        set_lu(5'd0, 5'd0, 1, 5'd0, 1);
        settle(); chk("r0_no_stall", {25'b0, outs()}, 32'h0);
        tick();
        set_lu(5'd7, 5'd7, 0, 5'd7, 0);
        settle(); chk("unused_no_stall", {25'b0, outs()}, 32'h0);
        tick();
        set_lu(5'd7, 5'd7, 1, 5'd0, 0); ex_memread = 0;
        settle(); chk("noload_no_stall", {25'b0, outs()}, 32'h0);
        tick(); clr();

        // branch beats load-use (and halt_req)
        set_lu(5'd5, 5'd5, 1, 5'd0, 0); ex_branch_taken = 1; halt_req = 1;
        settle();
        chk("branch_over_lu", {25'b0, outs()}, 32'h06);
        tick(); clr();

        // halt for 10 cycles, with noise that must be ignored
        halt_req = 1;
        settle();
        chk("halt_req_cycle", {25'b0, outs()}, 32'h60);
        tick(); clr();
        for (int i = 0; i < 10; i++) begin
            mem_busy = i[0]; ex_branch_taken = i[1]; halt_req = i[2];
            settle();
            chk("halted_hold", {25'b0, outs()}, 32'h63);
            tick();
        end
        clr(); go = 1;
        settle();
        chk("go_cycle_still_halted", {31'b0, halted}, 32'h1);
        tick(); go = 0;
        settle();
        chk("resumed", {25'b0, outs()}, 32'h0);
        tick();

        // reset in MEMWAIT
        mem_busy = 1;
        tick();
        rst = 1;
        settle();
        chk("rst_in_memwait_outs", {25'b0, outs()}, 32'h0);
        tick();
        rst = 0; mem_busy = 0;
        settle();
        chk("after_rst_memwait", {25'b0, outs()}, 32'h0);
        tick();

        // reset in HALT
        halt_req = 1;
        tick(); clr();
        settle();
        chk("in_halt", {31'b0, halted}, 32'h1);
        tick();
        rst = 1;
        settle();
        chk("rst_in_halt_outs", {25'b0, outs()}, 32'h0);
        tick();
        rst = 0;
        settle();
        chk("after_rst_halt", {31'b0, halted}, 32'h0);
        chk("after_rst_cnt", stall_cnt, 32'h0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port id_rs  in  5  rs field of the instruction in ID.
REQ-004 SHALL have port id_rt  in  5  rt field of the instruction in ID.
REQ-005 SHALL have port id_use_rs  in  1  ID instruction reads rs.
REQ-006 SHALL have port id_use_rt  in  1  ID instruction reads rt.
REQ-007 SHALL have port ex_memread  in  1  EX instruction is a load.
REQ-008 SHALL have port ex_rd  in  5  destination register of EX instruction.
REQ-009 SHALL have port ex_branch_taken  in  1  taken branch/jump resolved in EX.
REQ-010 SHALL have port mem_busy  in  1  data memory wait request.
REQ-011 SHALL have port halt_req  in  1  ID instruction is halt (syscall).
REQ-012 SHALL have port go  in  1  resume request while halted.
REQ-013 SHALL have ports pc_pause, ifid_pause, idex_pause, exmem_pause  out  1 each  hold the PC / pipeline register.
REQ-014 SHALL have ports ifid_flush, idex_flush  out  1 each  load a bubble (zeros) into IF/ID or ID/EX.
REQ-015 SHALL have port halted  out  1  high while in HALT.
REQ-016 SHALL have port stall_cnt  out  32  stall-cycle counter (see Configuration).

Function
REQ-017 SHALL hold a registered state: RUN, MEMWAIT, HALT; all control outputs combinational from state and inputs.
REQ-018 SHALL define load_use = ex_memread & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-019 SHALL apply priority in RUN: mem_busy > ex_branch_taken > load_use > halt_req.
REQ-020 SHALL, when mem_busy=1 in any non-HALT state, assert all four pause outputs, deassert both flushes, and enter/stay MEMWAIT next cycle.
REQ-021 SHALL, in MEMWAIT with mem_busy=0, behave as RUN for that cycle (priority evaluated normally) and return to RUN.
REQ-022 SHALL, on ex_branch_taken (no mem_busy), assert ifid_flush and idex_flush, no pauses; load_use and halt_req ignored that cycle.
REQ-023 SHALL, on load_use (no mem_busy/branch), assert pc_pause, ifid_pause, idex_flush for exactly that cycle; no other outputs.
REQ-024 SHALL, on halt_req (no higher event), assert pc_pause and ifid_pause, and enter HALT next cycle.
REQ-025 SHALL, in HALT, assert pc_pause, ifid_pause, idex_flush and halted; ignore mem_busy, branch, halt_req.
REQ-026 SHALL, in HALT with go=1, return to RUN next cycle; outputs still HALT values during the go cycle.
REQ-027 SHALL treat register 0 as never hazardous (no stall when ex_rd=0).
REQ-028 SHALL deassert every output in RUN with no event.

Reset
REQ-029 SHALL, with rst=1 at posedge clk, set state RUN and stall_cnt 0, overriding all inputs including go/mem_busy.
REQ-030 SHALL, while rst=1, drive all pause/flush outputs and halted to 0 combinationally.
REQ-031 SHALL, on rst mid-HALT or mid-MEMWAIT, resume in RUN on the first cycle after rst falls.

Configuration
REQ-032 SHALL compile the stall counter only when macro PIPE_HAZARD_STALL_CNT_EN is defined.
REQ-033 SHALL, with PIPE_HAZARD_STALL_CNT_EN, increment stall_cnt by 1 each cycle pc_pause=1 and rst=0, saturating at 32'hFFFFFFFF.
REQ-034 SHALL, without PIPE_HAZARD_STALL_CNT_EN, tie stall_cnt to 32'h0 with no counter register.

Verification
REQ-035 SHALL cover load-use: ex_memread=1, ex_rd=5, id_rs=5, id_use_rs=1 -> one cycle pc_pause=ifid_pause=idex_flush=1; ex_rd=0 case -> no outputs.
REQ-036 SHALL cover branch over load-use: ex_branch_taken=1 with load_use true -> ifid_flush=idex_flush=1, pc_pause=0.
REQ-037 SHALL cover mem_busy held 3 cycles with branch asserted -> 3 cycles all pauses=1, flushes=0; branch flush on 4th cycle when mem_busy=0.
REQ-038 SHALL cover halt: halt_req=1 -> halted=1 next cycle, stays with go=0 for 10 cycles; go=1 -> halted=0 following cycle.
REQ-039 SHALL cover rst asserted in HALT -> next cycle state RUN, halted=0, stall_cnt=0.
REQ-040 SHALL cover counter: with macro, 4 load-use stalls + 3 mem_busy cycles -> stall_cnt=7; without macro -> stall_cnt=0.
